// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one 2-byte UART transmitter among NUM_REQ level requesters.
// Latency: req -> grant edge, tx_en the following cycle; ack one cycle after tx_done, then GAP_CYCLES idle.
// Backpressure: req held until ack; the TX_TIMEOUT_EN build adds a tx_done watchdog and a sticky err.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                    clk_9k6hz,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      ack,
    output logic [2:0]              grant_id,
    output logic                    busy,
    output logic                    tx_en,
    output logic [15:0]             tx_data,
    input  logic                    tx_done,
    output logic                    err
);

    localparam int         IDW      = $clog2(NUM_REQ);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || GAP_CYCLES > 15 || TIMEOUT_CYCLES < 1)
    begin : g_bad_cfg
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       gap_cnt;
    logic             pick_vld;
    logic [IDW-1:0]   pick_idx;
    logic             timeout;
    logic [15:0]      words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[16*i +: 16];
    end

    // Scan downward so the lowest offset past the rr pointer wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[IDW'((int'(grant_id) + k) % NUM_REQ)]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'((int'(grant_id) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = BUSY;
            BUSY:    if (tx_done || timeout) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ack      <= '0;
            grant_id <= 3'(NUM_REQ - 1);
            busy     <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= 16'h0000;
            gap_cnt  <= 4'd0;
        end else begin
            state   <= state_nxt;
            tx_en   <= (state_nxt == LAUNCH);
            ack     <= '0;
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
            if (state == IDLE && pick_vld) begin
                grant_id <= 3'(pick_idx);
                tx_data  <= words[pick_idx];
                busy     <= 1'b1;
            end else if (state != IDLE && state_nxt == IDLE) begin
                busy <= 1'b0;
            end
            // A timed-out frame is not acknowledged.
            if (state == BUSY && tx_done)
                ack <= NUM_REQ'(1) << grant_id;
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wd_cnt;

    assign timeout = (state == BUSY) && !tx_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk_9k6hz or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= 16'd0;
            err    <= 1'b0;
        end else begin
            wd_cnt <= (state == BUSY) ? wd_cnt + 16'd1 : 16'd0;
            if (timeout)
                err <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench for uart_tx_arbiter: expected (id, word) pushed per frame, popped on tx_en.
// A small transmitter model answers each tx_en with tx_done after TX_LAT cycles.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TX_LAT  = 6;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] data;
    } exp_t;

    logic                  clk_9k6hz;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic [2:0]            grant_id;
    logic                  busy;
    logic                  tx_en;
    logic [15:0]           tx_data;
    logic                  tx_done;
    logic                  err;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          tx_cnt = 0;
    int          done_cyc = 0;
    int          ack_cyc = 0;
    int          txen_cyc = 0;
    int          gap_cd = 0;
    bit          ack_cyc_vld = 0;
    bit          frame_open = 0;
    bit          contend = 0;
    bit          tx_stall = 0;
    bit          stray_done = 0;
    bit          txen_prev = 0;
    logic [2:0]  cur_id = '0;
    logic [15:0] cur_data = '0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(2), .TIMEOUT_CYCLES(32)) dut (
        .clk_9k6hz (clk_9k6hz),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .err       (err)
    );

    initial clk_9k6hz = 1'b0;
    always #5 clk_9k6hz = ~clk_9k6hz;
    always @(posedge clk_9k6hz) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_exp(input int id, input logic [15:0] data);
        exp_t e;
        e.id   = 3'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [15:0] w);
        req_data[16*i +: 16] = w;
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        do begin @(negedge clk_9k6hz); n++; end while (ack == '0 && n < 200);
        check_eq({tag, "_ack_seen"}, 32'(ack != '0), 1);
    endtask

    task automatic wait_txen(input string tag);
        int n = 0;
        do begin @(negedge clk_9k6hz); n++; end while (!tx_en && n < 200);
        check_eq({tag, "_txen_seen"}, 32'(tx_en), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin @(negedge clk_9k6hz); n++; end while (busy && n < 200);
        check_eq({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tx_cnt = 0;
        frame_open = 0;
        ack_cyc_vld = 0;
        gap_cd = 0;
        repeat (2) @(negedge clk_9k6hz);
        rst_n = 1'b1;
        @(negedge clk_9k6hz);
    endtask

    // Transmitter model plus stray tx_done injection.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(posedge clk_9k6hz);
            #1;
            tx_done = stray_done;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0 && !tx_stall) begin
                    tx_done  = 1'b1;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Output monitor: scoreboard pop on tx_en, ack and gap timing.
    always @(negedge clk_9k6hz) begin
        if (rst_n) begin
            if (gap_cd == 2) check_eq("gap_busy_hold", 32'(busy), 1);
            if (gap_cd == 1) check_eq("gap_busy_drop", 32'(busy), 0);
            if (gap_cd > 0) gap_cd--;
            if (txen_prev) check_eq("txen_one_cycle", 32'(tx_en), 0);
            txen_prev = tx_en;
            if (tx_en) begin
                check_eq("txen_ack_excl", 32'(ack), 0);
                check_eq("txen_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("grant_id", 32'(grant_id), 32'(e.id));
                    check_eq("tx_data", 32'(tx_data), 32'(e.data));
                    cur_id   = e.id;
                    cur_data = e.data;
                end
                if (contend && ack_cyc_vld) check_eq("frame_gap", cyc - ack_cyc, 3);
                ack_cyc_vld = 0;
                frame_open  = 1;
                txen_cyc    = cyc;
                tx_cnt      = TX_LAT;
            end
            if (ack != '0) begin
                check_eq("ack_open", 32'(frame_open), 1);
                check_eq("ack_id", 32'(ack), 32'(1) << cur_id);
                check_eq("ack_latency", cyc - done_cyc, 1);
                check_eq("data_hold", 32'(tx_data), 32'(cur_data));
                frame_open  = 0;
                ack_cyc     = cyc;
                ack_cyc_vld = 1;
                gap_cd      = 2;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        @(negedge clk_9k6hz);
        check_eq("rst_ack", 32'(ack), 0);
        check_eq("rst_grant_id", 32'(grant_id), 3);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_tx_en", 32'(tx_en), 0);
        check_eq("rst_tx_data", 32'(tx_data), 0);
        check_eq("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        @(negedge clk_9k6hz);

        // Single requester
        set_word(1, 16'hA55A);
        push_exp(1, 16'hA55A);
        req = 4'b0010;
        wait_txen("single");
        check_eq("single_busy", 32'(busy), 1);
        wait_ack("single");
        req = '0;
        wait_idle("single");

        // Full contention from reset pointer 3
        do_reset();
        for (int i = 0; i < 4; i++) set_word(i, 16'(i + 1));
        foreach (exp_q[i]) check_eq("q_empty_before_contend", 0, 1);
        for (int i = 0; i < 5; i++) push_exp(i % 4, 16'((i % 4) + 1));
        contend = 1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_ack("contend");
        req = '0;
        contend = 0;
        wait_idle("contend");

        // Fairness: 2 held, 0 joins mid-frame
        set_word(2, 16'h2222);
        set_word(0, 16'h0F0F);
        push_exp(2, 16'h2222);
        push_exp(0, 16'h0F0F);
        push_exp(2, 16'h2222);
        req = 4'b0100;
        wait_txen("rr");
        req[0] = 1'b1;
        wait_ack("rr_first2");
        wait_ack("rr_then0");
        req[0] = 1'b0;
        wait_ack("rr_second2");
        req = '0;
        wait_idle("rr");

        // Word change after grant must not reach tx_data
        set_word(3, 16'h1234);
        push_exp(3, 16'h1234);
        req = 4'b1000;
        wait_txen("stab");
        set_word(3, 16'hFFFF);
        wait_ack("stab");
        req = '0;
        wait_idle("stab");
        check_eq("stab_data_idle", 32'(tx_data), 32'h1234);

        // Stray tx_done while idle
        stray_done = 1'b1;
        @(negedge clk_9k6hz);
        stray_done = 1'b0;
        @(negedge clk_9k6hz);
        check_eq("stray_ack", 32'(ack), 0);
        check_eq("stray_busy", 32'(busy), 0);

        // Reset in the middle of a frame
        set_word(1, 16'hBEEF);
        push_exp(1, 16'hBEEF);
        req = 4'b0010;
        wait_txen("abort");
        repeat (2) @(negedge clk_9k6hz);
        #2;
        rst_n = 1'b0;
        tx_cnt = 0;
        frame_open = 0;
        #1;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_grant_id", 32'(grant_id), 3);
        check_eq("abort_tx_data", 32'(tx_data), 0);
        check_eq("abort_ack", 32'(ack), 0);
        check_eq("abort_tx_en", 32'(tx_en), 0);
        repeat (2) @(negedge clk_9k6hz);
        set_word(0, 16'h0A0A);
        set_word(3, 16'h3A3A);
        push_exp(0, 16'h0A0A);
        push_exp(3, 16'h3A3A);
        req = 4'b1001;
        rst_n = 1'b1;
        wait_ack("post_rst0");
        req[0] = 1'b0;
        wait_ack("post_rst3");
        req = '0;
        wait_idle("post_rst");

`ifdef TX_TIMEOUT_EN
        begin
            int n = 0;
            set_word(2, 16'h7777);
            push_exp(2, 16'h7777);
            push_exp(2, 16'h7777);
            tx_stall = 1;
            req = 4'b0100;
            wait_txen("wd");
            while (!err && n < 80) begin @(negedge clk_9k6hz); n++; end
            check_eq("wd_err", 32'(err), 1);
            check_eq("wd_latency", cyc - txen_cyc, 33);
            frame_open = 0;
            tx_stall = 0;
            wait_ack("wd_next");
            req = '0;
            wait_idle("wd");
            check_eq("wd_err_sticky", 32'(err), 1);
        end
`else
        check_eq("err_tied", 32'(err), 0);
`endif

        check_eq("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
